// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch prefetch stage.
// The entry widths bound the ADDR_W/DATA_W parameters of the stage.
package if_pkg;

    localparam int PC_W   = 30;
    localparam int INSN_W = 32;

    localparam logic [INSN_W-1:0] NOP_INSN = '0;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INSN_W-1:0] insn;
    } fetch_entry_t;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Synchronous FIFO of fetch entries; clear wins over a same-cycle push.
// DEPTH must be a power of two so the pointers wrap naturally.
module if_prefetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    push,
    input  fetch_entry_t            push_data,
    input  logic                    pop,
    output fetch_entry_t            head,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    full,
    output logic                    empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            assert (!(push && full));
            assert (!(pop && empty));
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count
    // define which slots are meaningful, and this keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (rst && !clear && push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: credit-limited prefetch into a small queue, with
// redirects discarding queued entries and counting in-flight reads to drop.
module if_prefetch_stage
    import if_pkg::*;
#(
    parameter int                ADDR_W   = PC_W,
    parameter int                DATA_W   = INSN_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_insn,
    output logic              if_en,
    output logic              busy
);

    localparam int CW = cnt_w(DEPTH);
    localparam int TW = CW + 2;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     discard_cnt;

    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic [TW-1:0]     credit_used;
    logic              grant;
    logic              rsp_owed;
    logic              rsp_keep;
    logic              out_load;
    logic              q_push;
    logic              q_pop;
    logic [CW-1:0]     q_count;
    logic              q_full;
    logic              q_empty;
    fetch_entry_t      q_head;
    fetch_entry_t      q_in;

    assign redirect = flush | br_taken;
    assign target   = flush ? new_pc : br_addr;

    // Every queued entry, in-flight read and read still to be discarded
    // holds one credit, which is what keeps the queue from overflowing.
    assign credit_used = TW'(q_count) + TW'(outstanding) + TW'(discard_cnt);
    assign mem_req     = !redirect && (credit_used < TW'(DEPTH));
    assign mem_addr    = fetch_pc;
    assign grant       = mem_req && mem_gnt;
    assign busy        = mem_req && !mem_gnt;

    // A response with nothing left to discard belongs to a live read.
    assign rsp_owed = mem_rvalid && (discard_cnt == '0);
    assign rsp_keep = rsp_owed && !redirect;

    assign out_load = !stall || !if_en;
    assign q_pop    = !redirect && out_load && !q_empty;
    assign q_push   = rsp_keep && (!out_load || !q_empty);
    assign q_in     = '{pc: PC_W'(resp_pc), insn: INSN_W'(mem_rdata)};

    if_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            if_pc       <= '0;
            if_insn     <= DATA_W'(NOP_INSN);
            if_en       <= 1'b0;
        end else if (redirect) begin
            fetch_pc    <= target;
            resp_pc     <= target;
            outstanding <= '0;
            // Whatever is still in flight becomes garbage; a response landing
            // now retires one of those reads immediately.
            discard_cnt <= discard_cnt + outstanding - CW'(mem_rvalid);
            if_en       <= 1'b0;
        end else begin
            if (grant)    fetch_pc <= fetch_pc + ADDR_W'(1);
            if (rsp_keep) resp_pc  <= resp_pc + ADDR_W'(1);
            outstanding <= outstanding + CW'(grant) - CW'(rsp_owed);
            if (mem_rvalid && !rsp_owed) discard_cnt <= discard_cnt - CW'(1);
            if (out_load) begin
                if (!q_empty) begin
                    if_pc   <= ADDR_W'(q_head.pc);
                    if_insn <= DATA_W'(q_head.insn);
                    if_en   <= 1'b1;
                end else if (rsp_keep) begin
                    if_pc   <= resp_pc;
                    if_insn <= mem_rdata;
                    if_en   <= 1'b1;
                end else begin
                    if_en   <= 1'b0;
                end
            end
            assert (credit_used <= TW'(DEPTH));
            assert (!mem_rvalid || outstanding != '0 || discard_cnt != '0);
            assert (!(q_push && q_full));
        end
    end

endmodule

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
- Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue and up to DEPTH outstanding memory reads.
- Sits between the instruction memory port and the ID stage; decouples fetch latency from decode stalls.
- Handles branch and flush redirects by discarding queued and in-flight instructions, so the latency of a response has no effect on redirect correctness.

Parameters:
- ADDR_W, 30, word-address width (PC counts words; +1 per instruction).
- DATA_W, 32, instruction width.
- DEPTH, 4, prefetch queue entries and maximum outstanding reads (power of two, >=2).
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- stall  in  1  ID cannot accept; hold if_* outputs.
- flush  in  1  pipeline flush; redirect to new_pc.
- new_pc  in  ADDR_W  flush target.
- br_taken  in  1  branch redirect.
- br_addr  in  ADDR_W  branch target.
- mem_req  out  1  read request valid.
- mem_addr  out  ADDR_W  read word address.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  in-order read data valid.
- mem_rdata  in  DATA_W  read data.
- if_pc  out  ADDR_W  PC of if_insn.
- if_insn  out  DATA_W  fetched instruction.
- if_en  out  1  if_pc/if_insn valid.
- busy  out  1  mem_req high and mem_gnt low.

Behaviour:
- Reset (rst==0 at edge):
  - fetch_pc and resp_pc take RESET_PC.
  - if_pc=0, if_insn=0, if_en=0.
  - Queue is emptied; outstanding and discard counters are 0.
  - A reset in the middle of traffic drops all pending responses: the discard counter is cleared, so the memory side must also be reset together with this block.
- Redirect:
  - redirect = flush | br_taken; flush has priority (target new_pc, otherwise br_addr).
  - In the redirect cycle mem_req=0.
  - At the edge: fetch_pc and resp_pc take the target; the queue is cleared; if_en takes 0 regardless of stall.
  - discard_cnt takes outstanding minus (1 if a response arrives this cycle and discard_cnt==0 else 0) plus the existing discard_cnt, adjusted for that response.
  - The response arriving in the redirect cycle is always dropped.
- Request:
  - mem_req = !redirect && (q_count + outstanding + discard_cnt) < DEPTH; mem_addr = fetch_pc.
  - On mem_req && mem_gnt: fetch_pc+1 (wraps modulo 2^ADDR_W), outstanding+1.
- Response:
  - mem_rvalid with discard_cnt>0: discard_cnt-1, data dropped.
  - Otherwise: outstanding-1, and {resp_pc, mem_rdata} is delivered; resp_pc+1 (wraps).
  - A grant and a response in the same cycle leave outstanding unchanged.
- Output register, loaded when !stall || !if_en:
  - If the queue is non-empty: pop the head into if_pc/if_insn, if_en=1.
  - Else, if a kept response arrives this cycle: bypass it directly, if_en=1 (latency rvalid to if_en = 1 cycle).
  - Else if_en=0.
  - When the queue is non-empty, a kept response is pushed.
- Stall: when stall && if_en, the outputs hold and kept responses are pushed. The credit rule guarantees no overflow; push when full is an assertion failure.
- Counters are $clog2(DEPTH+1) bits wide. q_count+outstanding+discard_cnt never exceeds DEPTH; assert this.
- busy = mem_req && !mem_gnt.

Decomposition:
- Shared package if_pkg holds:
  - fetch_entry_t struct {pc[ADDR_W], insn[DATA_W]};
  - the NOP/zero constant for if_insn;
  - a cnt_w() helper function.
- Sub-module if_prefetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, clear, count, full and empty. Clear has priority over push in the same cycle. Credit, discard and redirect logic stays in the top module.

Test Plan:
- Reset, memory granting every cycle with 1-cycle rvalid, no stall: if_en rises 3 cycles after reset deasserts; if_pc runs 0,1,2,3 with matching data, one per cycle.
- DEPTH=4, stall held for 10 cycles:
  - mem_req drops once 4 entries are held (queue plus outstanding);
  - no data is lost;
  - after stall is released, if_pc continues sequentially.
- 3 outstanding reads with 5-cycle latency, br_taken with br_addr=0x100:
  - the 3 late responses are dropped (discard_cnt 3 to 0);
  - the next if_pc is 0x100.
- flush=1 and br_taken=1 in the same cycle (new_pc=0x40, br_addr=0x80) while stall=1: if_en=0 next cycle; the first valid if_pc is 0x40.
- fetch_pc=2^ADDR_W-1: the next fetch address wraps to 0; if_pc follows max then 0.
- rst asserted while 2 reads are outstanding (the memory model is reset too): all counters are 0, if_en=0, and the first request after release goes to RESET_PC.
